// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM states, access-size codes and byte-enable helper for data_cache
package dcache_pkg;

    typedef enum logic [2:0] {IDLE, FILL, WRITE, BYPASS, DONE} dcache_state_t;

    localparam logic [1:0] ADDR_BYTE = 2'b00;
    localparam logic [1:0] ADDR_HALF = 2'b01;
    localparam logic [1:0] ADDR_WORD = 2'b10;

    function automatic logic [3:0] byte_enable(input logic [1:0] mode, input logic [1:0] off);
        return mode == ADDR_BYTE ? 4'b0001 << off : mode == ADDR_HALF ? 4'b0011 << off : 4'b1111;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] off);
        return (mode == ADDR_HALF && off[0]) || (mode == ADDR_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/dcache_load_align.sv
// dcache_load_align: picks byte/half/word out of a cache line and sign- or zero-extends it
module dcache_load_align
    import dcache_pkg::*;
(
    input  logic [31:0] line,
    input  logic [1:0]  off,
    input  logic [2:0]  ctrl,
    output logic [31:0] rd
);

    logic [7:0]  b;
    logic [15:0] h;

    // extract the addressed lane, extend unless ctrl[2] asks for zero-extension
    always_comb begin
        b  = line[8*off +: 8];
        h  = line[16*off[1] +: 16];
        rd = ctrl[1:0] == ADDR_BYTE ? {{24{~ctrl[2] & b[7]}}, b} :
             ctrl[1:0] == ADDR_HALF ? {{16{~ctrl[2] & h[15]}}, h} :
             ctrl[1:0] == ADDR_WORD ? line : '0;
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through no-write-allocate L1 D-cache; DCACHE_STATS_EN adds hit/miss counters
module data_cache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic                  RE,
    input  logic                  WE,
    input  logic [2:0]            AddressingControl,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [2:0]            mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int SETS  = 2 ** SET_BITS;
    localparam int TAG_W = DATA_WIDTH - 2 - SET_BITS;

    dcache_state_t state, next_state;

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tags  [SETS];
    logic [DATA_WIDTH-1:0] lines [SETS];

    logic [DATA_WIDTH-1:0] addr_q, wd_q, bypass_q;
    logic [2:0]            ctrl_q;
    logic                  was_bypass, from_fill;

    logic [SET_BITS-1:0]   index, index_q;
    logic [TAG_W-1:0]      tag, tag_q;
    logic [1:0]            mode;
    logic                  reserved, misaligned, hit, load, store, handshake, hit_q;
    logic [DATA_WIDTH-1:0] aligned_rd, shifted_wd, merged;
    logic [3:0]            be;

    assign index      = A[SET_BITS+1:2];
    assign tag        = A[DATA_WIDTH-1:SET_BITS+2];
    assign mode       = AddressingControl[1:0];
    assign reserved   = &mode;
    assign misaligned = is_misaligned(mode, A[1:0]);
    assign hit        = valid[index] && tags[index] == tag;
    assign load       = RE && !WE && !reserved;
    assign store      = WE && !reserved;
    assign handshake  = mem_req && mem_ready;

    assign index_q    = addr_q[SET_BITS+1:2];
    assign tag_q      = addr_q[DATA_WIDTH-1:SET_BITS+2];
    assign hit_q      = valid[index_q] && tags[index_q] == tag_q;
    assign be         = byte_enable(ctrl_q[1:0], addr_q[1:0]);
    assign shifted_wd = wd_q << {addr_q[1:0], 3'b000};

    assign mem_req    = state inside {FILL, WRITE, BYPASS};
    assign mem_we     = state == WRITE;
    assign mem_addr   = state == FILL ? {addr_q[DATA_WIDTH-1:2], 2'b00} : addr_q;
    assign mem_ctrl   = state == FILL ? 3'b010 : ctrl_q;
    assign mem_wdata  = wd_q;

    dcache_load_align u_align (
        .line (lines[index]),
        .off  (A[1:0]),
        .ctrl (AddressingControl),
        .rd   (aligned_rd)
    );

    // byte-lane merge of a store into the currently cached word
    always_comb begin
        merged = lines[index_q];
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = shifted_wd[8*i +: 8];
    end

    // FSM next state plus the stall/RD outputs that depend on it
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        RD         = '0;
        case (state)
            IDLE: begin
                next_state = store ? WRITE : load && misaligned ? BYPASS : load && !hit ? FILL : IDLE;
                RD         = load && !misaligned && hit ? aligned_rd : '0;
                stall      = next_state != IDLE;
            end
            FILL: begin
                stall      = 1'b1;
                next_state = handshake ? IDLE : FILL;
            end
            WRITE: begin
                stall      = 1'b1;
                next_state = handshake ? DONE : WRITE;
            end
            BYPASS: begin
                stall      = 1'b1;
                next_state = handshake ? DONE : BYPASS;
            end
            DONE: begin
                next_state = IDLE;
                RD         = was_bypass ? bypass_q : hit && !misaligned ? aligned_rd : '0;
            end
            default: next_state = IDLE;
        endcase
        stall = stall && rst_n;
    end

    // state register and the access fields captured when leaving IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wd_q       <= '0;
            ctrl_q     <= '0;
            bypass_q   <= '0;
            was_bypass <= 1'b0;
            from_fill  <= 1'b0;
        end else begin
            state      <= next_state;
            was_bypass <= state == BYPASS;
            from_fill  <= state == FILL && handshake;
            if (state == IDLE && next_state != IDLE) begin
                addr_q <= A;
                wd_q   <= WD;
                ctrl_q <= AddressingControl;
            end
            if (state == BYPASS && handshake)
                bypass_q <= mem_rdata;
        end
    end

    // valid bits: cleared by reset, set when a fill completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (state == FILL && handshake)
            valid[index_q] <= 1'b1;
    end

    // tag and data arrays: line fill, or byte merge for an aligned store hit
    always_ff @(posedge clk) begin
        if (state == FILL && handshake) begin
            tags[index_q]  <= tag_q;
            lines[index_q] <= mem_rdata;
        end else if (state == WRITE && handshake && hit_q && !is_misaligned(ctrl_q[1:0], addr_q[1:0])) begin
            lines[index_q] <= merged;
        end
    end

`ifdef DCACHE_STATS_EN
    // hits exclude the replayed load right after a fill; misses count fill entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && load && !misaligned && hit && !from_fill)
                hit_count <= hit_count + 32'd1;
            if (state == IDLE && next_state == FILL)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with a small data_mem responder
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, WD, RD, mem_addr, mem_wdata, mem_rdata;
    logic        RE, WE, stall, mem_req, mem_we, mem_ready;
    logic [2:0]  AddressingControl, mem_ctrl;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    logic [31:0] mem_model [logic [29:0]];
    logic [31:0] bypass_val = 32'h0;
    logic        mem_en = 1'b1;
    int          lat_cnt = 0;
    int          rd_hs = 0;
    int          wr_hs = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    data_cache dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .A                 (A),
        .RE                (RE),
        .WE                (WE),
        .AddressingControl (AddressingControl),
        .WD                (WD),
        .RD                (RD),
        .stall             (stall),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_ctrl          (mem_ctrl),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // data_mem model: two-cycle latency, word reads from the model, sub-word reads return bypass_val
    always @(negedge clk) begin
        if (mem_req && mem_en) begin
            lat_cnt   = lat_cnt + 1;
            mem_ready = lat_cnt >= 2;
            mem_rdata = mem_ctrl == 3'b010 ? (mem_model.exists(mem_addr[31:2]) ? mem_model[mem_addr[31:2]] : 32'h0) : bypass_val;
        end else begin
            lat_cnt   = 0;
            mem_ready = 1'b0;
        end
    end

    // handshake log; full-word writes update the backing model
    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                wr_hs = wr_hs + 1;
                if (mem_ctrl == 3'b010) mem_model[mem_addr[31:2]] = mem_wdata;
            end else begin
                rd_hs = rd_hs + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stall_low(input string tag);
        int n = 0;
        while (stall && n < 50) begin
            tick();
            n++;
        end
        check(tag, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        mem_model[30'h10000 >> 2] = 32'h8000_00F0;
        mem_model[30'h10040 >> 2] = 32'h1111_2222;
        mem_model[30'h20080 >> 2] = 32'h55AA_1234;
        rst_n = 1'b0; RE = 1'b0; WE = 1'b0; A = 32'h0; WD = 32'h0; AddressingControl = 3'b010;
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_rd", RD, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // lw 0x10000: miss and fill
        A = 32'h0001_0000; RE = 1'b1; AddressingControl = 3'b010;
        #1;
        check("lw_miss_stall", {31'd0, stall}, 32'd1);
        tick();
        check("fill_req", {31'd0, mem_req}, 32'd1);
        check("fill_we", {31'd0, mem_we}, 32'd0);
        check("fill_addr", mem_addr, 32'h0001_0000);
        check("fill_ctrl", {29'd0, mem_ctrl}, 32'd2);
        wait_stall_low("fill_timeout");
        check("fill_rd", RD, 32'h8000_00F0);
        check("fill_rd_hs", rd_hs, 32'd1);
        tick();
        check("hit_stall", {31'd0, stall}, 32'd0);
        check("hit_rd", RD, 32'h8000_00F0);
        check("hit_no_req", {31'd0, mem_req}, 32'd0);

        // extraction: lb, lbu, lh, lhu
        AddressingControl = 3'b000; #1;
        check("lb", RD, 32'hFFFF_FFF0);
        AddressingControl = 3'b100; #1;
        check("lbu", RD, 32'h0000_00F0);
        A = 32'h0001_0002; AddressingControl = 3'b001; #1;
        check("lh_off2", RD, 32'hFFFF_8000);
        AddressingControl = 3'b101; #1;
        check("lhu_off2", RD, 32'h0000_8000);
        check("extract_stall", {31'd0, stall}, 32'd0);
        check("extract_rd_hs", rd_hs, 32'd1);

        // sb 0xAB to 0x10001 on a cached line
        RE = 1'b0; WE = 1'b1; A = 32'h0001_0001; WD = 32'h0000_00AB; AddressingControl = 3'b000;
        #1;
        check("sb_stall", {31'd0, stall}, 32'd1);
        tick();
        check("sb_req", {31'd0, mem_req}, 32'd1);
        check("sb_we", {31'd0, mem_we}, 32'd1);
        check("sb_addr", mem_addr, 32'h0001_0001);
        check("sb_ctrl", {29'd0, mem_ctrl}, 32'd0);
        check("sb_wdata", mem_wdata, 32'h0000_00AB);
        wait_stall_low("sb_timeout");
        check("sb_wr_hs", wr_hs, 32'd1);
        check("sb_done_rd", RD, 32'hFFFF_FFAB);
        WE = 1'b0; RE = 1'b1; A = 32'h0001_0000; AddressingControl = 3'b010;
        tick();
        check("sb_merge_rd", RD, 32'h8000_ABF0);
        check("sb_merge_stall", {31'd0, stall}, 32'd0);

        // sw to uncached 0x10040: no allocate
        RE = 1'b0; WE = 1'b1; A = 32'h0001_0040; WD = 32'hDEAD_BEEF; AddressingControl = 3'b010;
        #1;
        check("sw_stall", {31'd0, stall}, 32'd1);
        tick();
        check("sw_we", {31'd0, mem_we}, 32'd1);
        check("sw_addr", mem_addr, 32'h0001_0040);
        wait_stall_low("sw_timeout");
        check("sw_wr_hs", wr_hs, 32'd2);
        check("sw_done_rd", RD, 32'h0);
        WE = 1'b0; RE = 1'b1;
        tick();
        check("sw_noalloc_miss", {31'd0, stall}, 32'd1);
        tick();
        check("sw_refill_addr", mem_addr, 32'h0001_0040);
        wait_stall_low("refill_timeout");
        check("sw_refill_rd", RD, 32'hDEAD_BEEF);
        check("sw_refill_rd_hs", rd_hs, 32'd2);
        A = 32'h0001_0000; #1;
        check("other_line_kept", RD, 32'h8000_ABF0);

        // misaligned lh at 0x10003: bypass
        bypass_val = 32'hFFFF_80AB;
        A = 32'h0001_0003; AddressingControl = 3'b001;
        #1;
        check("byp_stall", {31'd0, stall}, 32'd1);
        tick();
        check("byp_addr", mem_addr, 32'h0001_0003);
        check("byp_ctrl", {29'd0, mem_ctrl}, 32'd1);
        check("byp_we", {31'd0, mem_we}, 32'd0);
        wait_stall_low("byp_timeout");
        check("byp_rd", RD, 32'hFFFF_80AB);
        check("byp_rd_hs", rd_hs, 32'd3);
        A = 32'h0001_0000; AddressingControl = 3'b010;
        tick();
        check("byp_valid_kept", RD, 32'h8000_ABF0);
        check("byp_valid_stall", {31'd0, stall}, 32'd0);

        // reserved access mode is ignored
        AddressingControl = 3'b011; #1;
        check("rsv_rd", RD, 32'h0);
        check("rsv_stall", {31'd0, stall}, 32'd0);
        tick();
        check("rsv_no_req", {31'd0, mem_req}, 32'd0);

        // reset during a fill with mem_ready held low
        mem_en = 1'b0;
        A = 32'h0002_0080; AddressingControl = 3'b010;
        tick();
        check("rst_fill_req", {31'd0, mem_req}, 32'd1);
        tick(); tick();
        check("rst_fill_held", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0; #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        tick();
        rst_n = 1'b1; mem_en = 1'b1; #1;
        check("rst_remiss", {31'd0, stall}, 32'd1);
        wait_stall_low("rst_refill_timeout");
        check("rst_refill_rd", RD, 32'h55AA_1234);
        check("rst_refill_rd_hs", rd_hs, 32'd4);
        RE = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
